// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard front end: folds E0/F0 prefixes into tagged key events and queues them in a FWFT FIFO.
// Optional prefix timeout is built when PS2_KBD_FIFO_TIMEOUT_EN is defined.
module ps2_kbd_fifo #(
    parameter int DEPTH          = 16,
    parameter int ERR_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic [7:0]               ps2_kbd_code_i,
    input  logic                     ps2_kbd_strobe_i,
    input  logic                     ps2_kbd_err_i,
    input  logic                     rd_i,
    output logic [9:0]               data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clr_overflow_i,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("ps2_kbd_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [9:0]           mem [DEPTH];

    logic                 push, do_push, do_pop, drop, err_evt, tmo_expire;
    logic [9:0]           ev_data;

`ifdef PS2_KBD_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Counts strobe-free cycles spent in a prefix state; a strobe or error preempts expiry.
    always_comb begin
        tmo_d      = tmo_q + 1'b1;
        tmo_expire = 1'b0;
        if (state_q == IDLE || ps2_kbd_strobe_i || ps2_kbd_err_i) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d      = '0;
            tmo_expire = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_evt = 1'b0;
        ev_data = {(state_q == BRK) || (state_q == EXT_BRK),
                   (state_q == EXT) || (state_q == EXT_BRK),
                   ps2_kbd_code_i};
        if (ps2_kbd_err_i) begin
            state_d = IDLE;
            err_evt = 1'b1;
        end else if (ps2_kbd_strobe_i) begin
            if (ps2_kbd_code_i == 8'hE0) begin
                state_d = EXT;
            end else if (ps2_kbd_code_i == 8'hF0) begin
                state_d = (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                push    = 1'b1;
                state_d = IDLE;
            end
        end else if (tmo_expire) begin
            state_d = IDLE;
            err_evt = 1'b1;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        do_pop   = rd_i && (count_q != '0);
        drop     = push && (count_q == CW'(DEPTH)) && !do_pop;
        do_push  = push && !drop;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d    = ovf_q;
        if (drop)                ovf_d = 1'b1;
        else if (clr_overflow_i) ovf_d = 1'b0;
        err_d    = err_evt ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= ev_data;
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = valid_o ? mem[rd_ptr_q] : 10'h000;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign err_cnt_o  = err_q;

endmodule
